// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner: blank gap, shared decoder, frame-sync double buffer.
// Define SEG_BRIGHTNESS_EN to add the bright[3:0] PWM duty input.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIGIT_CYC      = 50000,
   parameter int BLANK_CYC      = 500,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lzb,
`ifdef SEG_BRIGHTNESS_EN
   input  logic [3:0]              bright,
`endif
   output logic [3:0]              dec_nib,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(DIGIT_CYC);
   localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] LAST_DRIVE = CW'(DIGIT_CYC - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic          OFF        = (SEG_ACTIVE_LOW != 0);
   localparam logic [6:0]    SEG_OFF    = {7{OFF}};

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] r_pend, r_shadow;
   logic [NUM_DIGITS-1:0]   r_pend_dp, r_shadow_dp;
   logic                    r_pend_valid;
   logic [6:0]              r_seg, w_seg_nxt;
   logic                    r_dp, w_dp_nxt;
   logic [NUM_DIGITS-1:0]   r_an_n, w_an_nxt, w_an_on;
   logic                    r_frame_done;
   logic [3:0]              w_nib;
   logic                    w_dp_sel;
   logic                    w_upper_zero;
   logic                    w_blank;
   logic                    w_last_blank, w_last_drive, w_boundary;
   logic                    w_duty_ok;

   always_comb begin
      w_nib        = '0;
      w_dp_sel     = 1'b0;
      w_upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == r_idx) begin
            w_nib    = r_shadow[4*i +: 4];
            w_dp_sel = r_shadow_dp[i];
         end
         if (IW'(i) >= r_idx && r_shadow[4*i +: 4] != 4'h0)
            w_upper_zero = 1'b0;
      end
   end

   assign w_blank      = lzb && (r_idx != '0) && w_upper_zero;
   assign w_last_blank = (r_state == ST_BLANK) && (r_cnt == LAST_BLANK);
   assign w_last_drive = (r_state == ST_DRIVE) && (r_cnt == LAST_DRIVE);
   assign w_boundary   = w_last_drive && (r_idx == LAST_IDX);

   always_comb begin
      w_an_on = '1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (IW'(i) == r_idx && digit_en[i] && !w_blank && w_duty_ok)
            w_an_on[i] = 1'b0;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_seg_nxt   = r_seg;
      w_dp_nxt    = r_dp;
      w_an_nxt    = '1;
      case (r_state)
         ST_BLANK: begin
            w_seg_nxt = SEG_OFF;
            w_dp_nxt  = OFF;
            if (w_last_blank) begin
               w_state_nxt = ST_DRIVE;
               w_seg_nxt   = dec_seg ^ SEG_OFF;
               w_dp_nxt    = w_dp_sel ^ OFF;
               w_an_nxt    = w_an_on;
            end
         end
         ST_DRIVE: begin
            if (w_last_drive) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
               w_seg_nxt   = SEG_OFF;
               w_dp_nxt    = OFF;
            end else begin
               w_an_nxt = w_an_on;
            end
         end
         default: w_state_nxt = ST_BLANK;
      endcase
   end

`ifdef SEG_BRIGHTNESS_EN
   localparam int DRV = DIGIT_CYC - BLANK_CYC;
   logic [3:0]  r_bright;
   logic [3:0]  w_bright;
   logic [31:0] w_d;

   // New slot uses the bright value being sampled on this very edge.
   always_comb begin
      w_bright  = (r_state == ST_BLANK) ? bright : r_bright;
      w_d       = 32'(w_cnt_nxt) - 32'(BLANK_CYC);
      w_duty_ok = (w_d * 32'd16) < ((32'(w_bright) + 32'd1) * 32'(DRV));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_bright <= '0;
      else if (w_last_blank) r_bright <= bright;
   end
`else
   assign w_duty_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_BLANK;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_seg        <= SEG_OFF;
         r_dp         <= OFF;
         r_an_n       <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_seg        <= w_seg_nxt;
         r_dp         <= w_dp_nxt;
         r_an_n       <= w_an_nxt;
         r_frame_done <= w_boundary;
      end
   end

   // Boundary transfer sees pending as it was before a same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend       <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_shadow     <= '0;
         r_shadow_dp  <= '0;
      end else begin
         if (w_boundary && r_pend_valid) begin
            r_shadow    <= r_pend;
            r_shadow_dp <= r_pend_dp;
         end
         if (wr_en) begin
            r_pend       <= wr_data;
            r_pend_dp    <= dp_in;
            r_pend_valid <= 1'b1;
         end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   assign dec_nib    = w_nib;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an_n       = r_an_n;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: cycle-position reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = N * DC;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b0;
   logic           wr_en    = 1'b0;
   logic [4*N-1:0] wr_data  = '0;
   logic [N-1:0]   dp_in    = '0;
   logic [N-1:0]   digit_en = '1;
   logic           lzb      = 1'b0;
   logic [3:0]     dec_nib;
   logic [6:0]     dec_seg;
   logic [6:0]     seg;
   logic           dp;
   logic [N-1:0]   an_n;
   logic           frame_done;
`ifdef SEG_BRIGHTNESS_EN
   logic [3:0]     bright = 4'hF;
`endif

   typedef struct packed {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp;
      logic         fd;
      logic [3:0]   nib;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   int             k        = 0;
   logic [4*N-1:0] m_shadow = '0;
   logic [4*N-1:0] m_pend   = '0;
   logic [N-1:0]   m_sdp    = '0;
   logic [N-1:0]   m_pdp    = '0;
   logic           m_pv     = 1'b0;

   seg_scan_ctrl #(
      .NUM_DIGITS(N), .DIGIT_CYC(DC), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .dp_in(dp_in), .digit_en(digit_en), .lzb(lzb),
`ifdef SEG_BRIGHTNESS_EN
      .bright(bright),
`endif
      .dec_nib(dec_nib), .dec_seg(dec_seg), .seg(seg), .dp(dp),
      .an_n(an_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   assign dec_seg = hex7(dec_nib);

   // Expected outputs from the cycle position k since reset.
   function automatic exp_t model_out();
      exp_t e;
      int pos, dig;
      bit hid;
      pos   = k % DC;
      dig   = (k / DC) % N;
      e.nib = m_shadow[4*dig +: 4];
      e.an  = '1;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.fd  = (k != 0) && (k % FRAME == 0);
      if (pos >= BC) begin
         e.seg = ~hex7(e.nib);
         e.dp  = ~m_sdp[dig];
         hid   = lzb && dig != 0 && ((m_shadow >> (4*dig)) == '0);
         if (digit_en[dig] && !hid) e.an[dig] = 1'b0;
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         m_shadow = '0; m_pend = '0;
         m_sdp = '0; m_pdp = '0; m_pv = 1'b0;
         sb_q.delete();
         sb_q.push_back(model_out());
      end else begin
         k++;
         if (k % FRAME == 0 && m_pv) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
            m_pv     = 1'b0;
         end
         if (wr_en) begin
            m_pend = wr_data;
            m_pdp  = dp_in;
            m_pv   = 1'b1;
         end
         sb_q.push_back(model_out());
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         m_e = sb_q.pop_front();
         chk("an_n",       32'(an_n),       32'(m_e.an));
         chk("seg",        32'(seg),        32'(m_e.seg));
         chk("dp",         32'(dp),         32'(m_e.dp));
         chk("frame_done", 32'(frame_done), 32'(m_e.fd));
         chk("dec_nib",    32'(dec_nib),    32'(m_e.nib));
      end
   end

   task automatic write(input logic [4*N-1:0] d, input logic [N-1:0] m);
      wr_data = d;
      dp_in   = m;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_k(input int target);
      int i;
      for (i = 0; i < 4*FRAME && (k % FRAME) != target; i++) @(negedge clk);
      if ((k % FRAME) != target) chk("wait_k_timeout", 32'(k), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog k=%0d actual=timeout required=finish", k);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (FRAME) @(negedge clk);

      repeat (10) @(negedge clk);
      write(16'h12AF, 4'h0);
      repeat (2*FRAME) @(negedge clk);

      lzb = 1'b1;
      write(16'h0005, 4'h0);
      repeat (2*FRAME) @(negedge clk);
      write(16'h0000, 4'h0);
      repeat (2*FRAME) @(negedge clk);
      lzb = 1'b0;

      wait_k(5);
      write(16'h2222, 4'h0);
      wait_k(FRAME-1);
      write(16'h3333, 4'h0);
      repeat (2*FRAME) @(negedge clk);

      digit_en = 4'b1010;
      write(16'h4321, 4'b0001);
      repeat (2*FRAME) @(negedge clk);
      digit_en = '1;

      for (int c = 0; c < 20*FRAME; c++) begin
         digit_en = N'($urandom);
         lzb      = 1'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            for (int j = 0; j < N; j++)
               wr_data[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            dp_in = N'($urandom);
            wr_en = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
      end
      wr_en    = 1'b0;
      digit_en = '1;
      lzb      = 1'b0;

      write(16'h9876, 4'b0100);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_k(12);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (FRAME + 8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Shares one hex-to-7-segment decoder across all digits: presents one nibble at a time, registers the decoded pattern, and drives the matching digit enable.
- Inserts an all-off blanking gap between digits to prevent ghosting.
- Double-buffers the displayed value so the new value is applied only at frame boundaries, which avoids tearing.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIGIT_CYC, 50000, clk cycles per digit slot, blanking included.
- BLANK_CYC, 500, all-off cycles at the start of each slot; requires 1 <= BLANK_CYC < DIGIT_CYC.
- SEG_ACTIVE_LOW, 1, 1 inverts seg/dp outputs (segment on = 0); 0 means segment on = 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  one-cycle strobe: capture wr_data into the pending register.
- wr_data  in  4*NUM_DIGITS  display value; digit i = wr_data[4i+3:4i], digit 0 = rightmost.
- dp_in  in  NUM_DIGITS  decimal-point mask, captured with wr_data.
- digit_en  in  NUM_DIGITS  live per-digit enable mask; 0 = digit always dark.
- lzb  in  1  leading-zero blanking enable (live).
- dec_nib  out  4  nibble presented to the shared decoder (combinational from state).
- dec_seg  in  7  decoder output, active-high, bit6 = a … bit0 = g.
- seg  out  7  segment drive, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal-point drive, same polarity as seg.
- an_n  out  NUM_DIGITS  digit enables, active-low.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state = BLANK, idx = 0, cnt = 0.
  - pending and shadow registers = 0; pend_valid = 0.
  - an_n = all 1s; seg and dp = segments-off level; frame_done = 0.
- Registers:
  - pending (value + dp mask) and pend_valid.
  - shadow (displayed value + dp mask).
  - idx, width clog2(NUM_DIGITS).
  - cnt, width clog2(DIGIT_CYC).
  - state.
- Write path: wr_en=1 loads pending and sets pend_valid. A later write before the frame boundary overwrites the earlier one; the last write wins.
- dec_nib = shadow nibble[idx], driven in every state.
- FSM:
  - BLANK:
    - an_n all 1s; seg/dp held at off level.
    - cnt counts 0..BLANK_CYC-1.
    - On the last BLANK cycle, seg <= dec_seg (polarity applied) and dp <= shadow dp[idx], both registered. Go to DRIVE.
  - DRIVE:
    - an_n[idx] = 0 only if digit_en[idx]=1 and the digit is not blanked; all other bits stay 1.
    - cnt continues from BLANK_CYC to DIGIT_CYC-1.
    - On the last cycle: cnt <= 0, idx <= idx+1, wrapping from NUM_DIGITS-1 to 0. Go to BLANK.
- Blank condition: lzb=1, idx != 0, and shadow nibbles idx..NUM_DIGITS-1 are all 0. Digit 0 is never blanked by lzb.
- Frame boundary = the last DRIVE cycle at idx = NUM_DIGITS-1. On the next edge:
  - frame_done pulses high for exactly 1 cycle.
  - If pend_valid, then shadow <= pending and pend_valid <= 0.
- Write at the boundary cycle: the transfer uses the pending contents from before that edge. The new write lands in pending with pend_valid=1 and is applied at the next frame.
- Timing:
  - Full frame = NUM_DIGITS*DIGIT_CYC cycles.
  - Worst-case write-to-display latency is one frame plus BLANK_CYC.
- Outputs are registered; no combinational path exists from inputs to an_n, seg or dp.
- A digit_en or lzb change takes effect at the next cycle on an_n (an_n is registered).
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The scan restarts at idx 0, state BLANK.

Optional Feature:
- Macro: SEG_BRIGHTNESS_EN.
- Enabled:
  - Adds input port bright [3:0].
  - Let DRV = DIGIT_CYC - BLANK_CYC and d = cnt - BLANK_CYC.
  - In DRIVE, the selected an_n bit is 0 only while 16*d < (bright+1)*DRV. bright=15 gives full duty; bright=0 gives 1/16 duty.
  - seg/dp stay valid for the whole of DRIVE.
  - bright is sampled at each BLANK→DRIVE transition.
- Disabled: no bright port; full duty throughout DRIVE.

Test Plan (NUM_DIGITS=4, DIGIT_CYC=8, BLANK_CYC=2, SEG_ACTIVE_LOW=1):
- Reset, then run 32 cycles, no writes → dec_nib=0 throughout. Each digit gets 2 cycles with an_n=1111, then 6 cycles with one bit low (order 1110, 1101, 1011, 0111). seg=7'b0000001 (decoded 0, inverted). frame_done high 1 cycle every 32.
- wr_en with wr_data=16'h12AF mid-frame → display unchanged until frame_done. Next frame: digit0 seg=~7'b1000111 (F), digit1 ~7'b1110111 (A), digit2 ~7'b1101101 (2), digit3 ~7'b0110000 (1).
- wr_data=16'h0005, lzb=1 → digits 3..1 keep an_n bit=1 during DRIVE, digit 0 lit with 5. wr_data=16'h0000, lzb=1 → only digit 0 lit, showing 0.
- wr_en=1 exactly on the boundary cycle with 16'h3333, while pending holds 16'h2222 → next frame shows 2222, the following frame 3333.
- digit_en=4'b1010, dp_in=4'b0001 → digits 0 and 2 never enabled. dp=0 (on) only in digit 0's slot, and that slot stays dark.
- rst_n pulled low at cycle 13 (digit 1, DRIVE) → same cycle an_n=1111, seg=1111111, frame_done=0. After release, the scan restarts at digit 0 in BLANK.
